// File: rtl/regfile_multiport.sv
// Multiport MIPS register file: N_READ registered read lanes, one write port,
// write-to-read bypass, hardwired zero, stall enable and post-reset clear.
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NB       = $clog2(DEPTH),
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    reg_write,
  input  logic [NB-1:0]           write_register,
  input  logic [WIDTH-1:0]        write_data,
  input  logic [N_READ*NB-1:0]    read_register,
  output logic [N_READ*WIDTH-1:0] read_data,
  input  logic [NB-1:0]           debug_addr,
  output logic [WIDTH-1:0]        debug_data,
  output logic                    ready
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [NB:0]   DEPTH_W = (NB+1)'(DEPTH);
  localparam logic [NB-1:0] LAST    = NB'(DEPTH - 1);

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [0:0]              state_q, state_d;
  logic [NB-1:0]           cnt_q, cnt_d;
  logic [N_READ*WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0]        dbg_q, dbg_d;
  logic                    run;
  logic                    wr_ok;

  function automatic logic in_range(input logic [NB-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero(input logic [NB-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Out-of-range and hardwired-zero addresses never touch the array
  function automatic logic [WIDTH-1:0] peek(input logic [NB-1:0] a);
    if (!in_range(a) || is_zero(a)) return '0;
    return mem_q[a];
  endfunction

  assign run   = (state_q == S_RUN);
  assign wr_ok = run && enable && reg_write
              && in_range(write_register)
              && !is_zero(write_register);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    dbg_d   = dbg_q;
    if (!run) begin
      cnt_d = cnt_q + NB'(1);
      if (cnt_q == LAST) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end else begin
      dbg_d = peek(debug_addr);
      if (enable) begin
        for (int k = 0; k < N_READ; k++) begin
          if (wr_ok && write_register == read_register[k*NB +: NB])
            rdata_d[k*WIDTH +: WIDTH] = write_data;
          else
            rdata_d[k*WIDTH +: WIDTH] = peek(read_register[k*NB +: NB]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      dbg_q   <= dbg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run)
        mem_q[cnt_q] <= '0;
      else if (wr_ok)
        mem_q[write_register] <= write_data;
    end
  end

  assign read_data  = rdata_q;
  assign debug_data = dbg_q;
  assign ready      = run;

endmodule
